// File: rtl/aes_pkg.sv
// Shared constants, FSM encoding and GF(2^8) helper for the iterative AES-128 round sequencer.
package aes_pkg;

    localparam int         NR_AES128 = 10;
    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1b;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } aes_state_e;

    // Multiply by x in GF(2^8); the same operation is the *2 term of mix_columns.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_rcon_round_cnt.sv
// Round counter and rcon register for the AES-128 sequencer; flags the final round (dp_last).
module aes_rcon_round_cnt
    import aes_pkg::*;
#(
    parameter int NR = NR_AES128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       step,
    input  logic       clear,
    output logic [7:0] rcon,
    output logic       last
);

    localparam int CW = $clog2(NR + 1);

    logic [CW-1:0] round_q;
    logic [7:0]    rcon_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            round_q <= '0;
            rcon_q  <= RCON_INIT;
        end else if (load) begin
            round_q <= CW'(1);
            rcon_q  <= RCON_INIT;
        end else if (step) begin
            round_q <= round_q + CW'(1);
            rcon_q  <= xtime(rcon_q);
        end else if (clear) begin
            round_q <= '0;
        end
    end

    assign rcon = rcon_q;
    assign last = (round_q == CW'(NR));

endmodule

// File: rtl/aes128_round_ctrl.sv
// Iterative AES-128 encryption sequencer owning state/key/round/rcon registers for an external round datapath.
// Optional AES_DP_REG_EN: two-phase rounds (issue, capture) for a datapath with an internal pipeline register.
module aes128_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR = NR_AES128,
    parameter int W  = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_pt,
    input  logic [W-1:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_ct,
    output logic [W-1:0] dp_state,
    output logic [W-1:0] dp_key,
    output logic [7:0]   dp_rcon,
    output logic         dp_last,
    input  logic [W-1:0] dp_next_state,
    input  logic [W-1:0] dp_next_key,
    output logic         busy
);

    aes_state_e   fsm_q, fsm_d;
    logic [W-1:0] state_q, key_q;
    logic         accept, capture, release_out, last;

    assign accept      = in_valid && in_ready;
    assign release_out = (fsm_q == DONE) && out_ready;

`ifdef AES_DP_REG_EN
    logic phase_q;  // 0: issue registers to datapath, 1: capture its pipelined result

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            phase_q <= 1'b0;
        else if (fsm_q == ROUND)
            phase_q <= ~phase_q;
        else
            phase_q <= 1'b0;
    end

    assign capture = (fsm_q == ROUND) && phase_q;
`else
    assign capture = (fsm_q == ROUND);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            fsm_q <= IDLE;
        else
            fsm_q <= fsm_d;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        fsm_d     = fsm_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (fsm_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    fsm_d = ROUND;
            end
            ROUND: begin
                busy = 1'b1;
                if (capture && last)
                    fsm_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    // NOTE: the wide data registers are reset because out_ct is visible straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= '0;
            key_q   <= '0;
        end else if (accept) begin
            state_q <= in_pt ^ in_key;
            key_q   <= in_key;
        end else if (capture) begin
            state_q <= dp_next_state;
            key_q   <= dp_next_key;
        end
    end

    aes_rcon_round_cnt #(
        .NR (NR)
    ) u_rcon_cnt (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .step  (capture),
        .clear (release_out),
        .rcon  (dp_rcon),
        .last  (last)
    );

    assign out_ct   = state_q;
    assign dp_state = state_q;
    assign dp_key   = key_q;
    assign dp_last  = last;

endmodule

// File: doc/aes128_round_ctrl.md
Name: aes128_round_ctrl

Overview:
Iterative AES-128 encryption sequencer that owns the 128-bit state register, the round-key register, the round counter and the rcon register.
- Drives an external combinational round datapath: sub_bytes -> shift_rows -> mix_columns -> add_round_key, plus one-step key expansion.
- One round per cycle (two with the optional feature).
- Valid/ready on both input and output sides.
- Sits between the block-cipher wrapper and the round datapath.

Parameters:
NR, 10, number of rounds; the final round skips mix_columns
W, 128, block and key width in bits

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  plaintext/key offered
in_ready  out  1  controller can accept
in_pt  in  128  plaintext, byte 0 in [127:120]
in_key  in  128  cipher key, same byte order
out_valid  out  1  ciphertext available
out_ready  in  1  consumer accepts ciphertext
out_ct  out  128  ciphertext (= state register)
dp_state  out  128  current state to datapath
dp_key  out  128  current round key to datapath
dp_rcon  out  8  rcon for next key-expansion step
dp_last  out  1  final round: datapath bypasses mix_columns
dp_next_state  in  128  datapath result, already XORed with dp_next_key
dp_next_key  in  128  expanded next round key
busy  out  1  high in ROUND state

Behaviour:
Reset, asynchronous on rst high:
- FSM -> IDLE; state, key and round counter cleared to 0; rcon = 8'h01.
- in_ready=1, out_valid=0, busy=0, dp_last=0.

FSM states: IDLE, ROUND, DONE.

IDLE:
- in_ready=1.
- On in_valid & in_ready: state <= in_pt ^ in_key (round-0 AddRoundKey), key <= in_key, round <= 1, rcon <= 01, go to ROUND.

ROUND:
- in_ready=0; in_valid is ignored and not queued.
- Each cycle: state <= dp_next_state, key <= dp_next_key, rcon <= xtime(rcon), round <= round+1.
- xtime(rcon) = rcon<<1, XOR 8'h1b if rcon[7] was 1. Sequence: 01,02,04,08,10,20,40,80,1b,36.
- dp_last = (round == NR).
- On the cycle with round == NR, go to DONE.

DONE:
- out_valid=1; out_ct is stable until out_ready is seen.
- On out_ready: go to IDLE, round <= 0.
- No input is accepted in DONE, so the minimum spacing between accepts is NR+2 cycles.

Latency:
- Accept at edge E0; NR round edges follow; out_valid rises after edge E10.
- out_valid is registered and has no combinational path from out_ready.

Counter width: ceil(log2(NR+1)) bits.

Reset mid-operation aborts the block immediately. No partial output is produced.

dp_state, dp_key and dp_rcon are driven directly from their registers in every state; their values outside ROUND are don't-care to the datapath.

Optional Feature:
AES_DP_REG_EN defined:
- ROUND has two phases. The ISSUE phase presents the registers to the datapath. The CAPTURE phase loads dp_next_state/dp_next_key after the datapath's internal pipeline register.
- Round latency is 2 cycles; out_valid rises 2*NR cycles after accept.
- dp_last holds across both phases of the final round.

AES_DP_REG_EN undefined: single-phase rounds as described above.

Decomposition:
Package aes_pkg holds:
- NR_AES128 = 10, RCON_INIT = 8'h01, RCON_POLY = 8'h1b
- FSM state enum {IDLE, ROUND, DONE}
- xtime function, shared with the mix_columns multiply-by-2

One natural sub-module: aes_rcon_round_cnt. It contains the round counter, the rcon register with xtime update, and generation of dp_last.

Test Plan:
- Checkpoint: after 10 rounds out_ct=69c4e0d86a7b0430d8cdb78070b4c55a.
  - Stimulus: real datapath attached; pt=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f.
  - Response: out_valid exactly 10 cycles after accept (20 with AES_DP_REG_EN).
- rcon trace on dp_rcon across rounds 1..10 = 01,02,04,08,10,20,40,80,1b,36; dp_last high only in round 10.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_ct and out_valid stable, in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1.
- in_valid held high throughout the first block with a second vector present -> second vector is accepted only after DONE->IDLE; no corruption of the first result.
- Assert rst during round 5 -> out_valid=0, in_ready=1, busy=0 immediately; a new FIPS vector afterwards yields the correct ciphertext.
- Back-to-back key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> out_ct=3925841d02dc09fbdc118597196a0b32.
